// File: rtl/jt900h_intseq_pkg.sv
// Shared definitions for the JT900H interrupt entry sequencer:
// state encoding, default vector table base and the IFF update rule.
package jt900h_intseq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PUSH_PC = 3'd1,
      ST_PUSH_SR = 3'd2,
      ST_SET_IFF = 3'd3,
      ST_RD_VEC  = 3'd4
   } state_t;

   localparam logic [23:0] VECBASE_DEF = 24'hFFFF00;

   // Level 7 is non-maskable, so it cannot raise the mask any further.
   function automatic logic [2:0] iff_next(input logic [2:0] lvl);
      return (lvl == 3'd7) ? 3'd7 : lvl + 3'd1;
   endfunction

endpackage

// File: rtl/jt900h_intseq_if.sv
// Memory-controller access channel used by the interrupt sequencer.
interface jt900h_intseq_if;
   logic        bus_req;
   logic        bus_we;
   logic        bus_ws;
   logic [23:0] bus_addr;
   logic [31:0] bus_dout;
   logic [31:0] bus_din;
   logic        bus_ack;

   modport master (
      output bus_req, bus_we, bus_ws, bus_addr, bus_dout,
      input  bus_din, bus_ack
   );

   modport slave (
      input  bus_req, bus_we, bus_ws, bus_addr, bus_dout,
      output bus_din, bus_ack
   );
endinterface

// File: rtl/jt900h_intseq.sv
// Interrupt entry sequencer: accepts an interrupt at an instruction boundary,
// pushes PC and SR on XSP, raises IFF, fetches the vector and loads PC.
module jt900h_intseq
   import jt900h_intseq_pkg::*;
#(
   parameter logic [23:0] VECBASE = VECBASE_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cen,
   input  logic [2:0]             int_lvl,
   input  logic [5:0]             int_vec,
   input  logic                   insn_end,
   input  logic [2:0]             imask,
   input  logic [31:0]            xsp,
   input  logic [23:0]            pc,
   input  logic [15:0]            sr,
   output logic                   busy,
   output logic                   int_ack,
   output logic [5:0]             ack_vec,
   jt900h_intseq_if.master        bus,
   output logic                   xsp_we,
   output logic [31:0]            xsp_nx,
   output logic                   pc_we,
   output logic [23:0]            pc_nx,
   output logic                   iff_we,
   output logic [2:0]             iff_nx
);

   state_t      state, state_nx;
   logic [2:0]  lvl_r;
   logic [5:0]  vec_r;
   logic        accept;
   logic [31:0] xsp_m4, xsp_m2;
   logic        unused_din;

   assign xsp_m4     = xsp - 32'd4;
   assign xsp_m2     = xsp - 32'd2;
   assign unused_din = ^bus.bus_din[31:24];

   // rst_n is included so no request can be acknowledged while reset is held.
   assign accept = rst_n && cen && insn_end && (int_lvl != 3'd0) &&
                   ((int_lvl >= imask) || (int_lvl == 3'd7));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         lvl_r <= 3'd0;
         vec_r <= 6'd0;
      end else if (cen) begin
         state <= state_nx;
         if (int_ack) begin
            lvl_r <= int_lvl;
            vec_r <= int_vec;
         end
      end
   end

   always_comb begin
      state_nx     = state;
      busy         = (state != ST_IDLE);
      int_ack      = 1'b0;
      ack_vec      = 6'd0;
      bus.bus_req  = 1'b0;
      bus.bus_we   = 1'b0;
      bus.bus_ws   = 1'b0;
      bus.bus_addr = 24'd0;
      bus.bus_dout = 32'd0;
      xsp_we       = 1'b0;
      xsp_nx       = 32'd0;
      pc_we        = 1'b0;
      pc_nx        = 24'd0;
      iff_we       = 1'b0;
      iff_nx       = 3'd0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               int_ack  = 1'b1;
               ack_vec  = int_vec;
               busy     = 1'b1;
               state_nx = ST_PUSH_PC;
            end
         end
         ST_PUSH_PC: begin
            bus.bus_req  = 1'b1;
            bus.bus_we   = 1'b1;
            bus.bus_addr = xsp_m4[23:0];
            bus.bus_dout = {8'd0, pc};
            if (cen && bus.bus_ack) begin
               xsp_we   = 1'b1;
               xsp_nx   = xsp_m4;
               state_nx = ST_PUSH_SR;
            end
         end
         // XSP input already reflects the PC push by the time we get here.
         ST_PUSH_SR: begin
            bus.bus_req  = 1'b1;
            bus.bus_we   = 1'b1;
            bus.bus_ws   = 1'b1;
            bus.bus_addr = xsp_m2[23:0];
            bus.bus_dout = {16'd0, sr};
            if (cen && bus.bus_ack) begin
               xsp_we   = 1'b1;
               xsp_nx   = xsp_m2;
               state_nx = ST_SET_IFF;
            end
         end
         ST_SET_IFF: begin
            iff_we = cen;
            iff_nx = iff_next(lvl_r);
            if (cen) state_nx = ST_RD_VEC;
         end
         ST_RD_VEC: begin
            bus.bus_req  = 1'b1;
            bus.bus_addr = VECBASE | {16'd0, vec_r, 2'b00};
            if (cen && bus.bus_ack) begin
               pc_we    = 1'b1;
               pc_nx    = bus.bus_din[23:0];
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_jt900h_intseq.sv
// Directed self-checking bench for jt900h_intseq with a small bus responder
// and a register-file model for XSP.
module tb_jt900h_intseq;
   import jt900h_intseq_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, cen, insn_end;
   logic [2:0]  int_lvl, imask;
   logic [5:0]  int_vec;
   logic [31:0] xsp;
   logic [23:0] pc;
   logic [15:0] sr;
   logic        busy, int_ack, xsp_we, pc_we, iff_we;
   logic [5:0]  ack_vec;
   logic [31:0] xsp_nx;
   logic [23:0] pc_nx;
   logic [2:0]  iff_nx;
   logic [128:0] all_out;

   jt900h_intseq_if bus_if();

   jt900h_intseq dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .int_lvl(int_lvl), .int_vec(int_vec),
      .insn_end(insn_end), .imask(imask), .xsp(xsp), .pc(pc), .sr(sr),
      .busy(busy), .int_ack(int_ack), .ack_vec(ack_vec), .bus(bus_if),
      .xsp_we(xsp_we), .xsp_nx(xsp_nx), .pc_we(pc_we), .pc_nx(pc_nx),
      .iff_we(iff_we), .iff_nx(iff_nx)
   );

   always #5 clk = ~clk;

   assign all_out = {busy, int_ack, ack_vec, bus_if.bus_req, bus_if.bus_we, bus_if.bus_ws,
                     bus_if.bus_addr, bus_if.bus_dout, xsp_we, xsp_nx, pc_we, pc_nx,
                     iff_we, iff_nx};

   int n_checks = 0;
   int n_pass   = 0;

   // Observations recorded by run_seq
   int          n_acc, busy_cyc, ack_cnt, unstable, bad_strobe, strobe_sig;
   logic [23:0] acc_addr [4];
   logic [31:0] acc_dout [4];
   logic        acc_we [4];
   logic        acc_ws [4];
   logic [2:0]  iff_val;
   logic [23:0] pc_val;
   logic [5:0]  ackvec_val;
   logic [31:0] xsp_nx_first, xsp_nx_last;
   bit          done;

   // Drives one interrupt entry; called at posedge+1 with inputs already set.
   task automatic run_seq(input int wait_n, input bit cen_tog, input bit mid_change,
                          input logic [31:0] rd_data);
      int          cnt;
      bit          hold, upd_x;
      logic [23:0] p_addr;
      logic [31:0] p_dout, upd_v;
      logic        p_we, p_ws;
      cnt = 0; hold = 0; p_addr = '0; p_dout = '0; p_we = 0; p_ws = 0;
      n_acc = 0; busy_cyc = 0; ack_cnt = 0; unstable = 0; bad_strobe = 0; strobe_sig = 0;
      iff_val = '0; pc_val = '0; ackvec_val = '0; xsp_nx_first = '0; xsp_nx_last = '0;
      done = 0;
      for (int c = 0; c < 200 && !done; c++) begin
         cen = cen_tog ? (c % 2 == 0) : 1'b1;
         bus_if.bus_ack = bus_if.bus_req && (cnt >= wait_n);
         bus_if.bus_din = (bus_if.bus_req && !bus_if.bus_we) ? rd_data : 32'hDEAD_BEEF;
         @(negedge clk);
         upd_x = 0; upd_v = '0;
         if (busy) busy_cyc++;
         if (int_ack) begin ack_cnt++; ackvec_val = ack_vec; end
         if (bus_if.bus_req) begin
            if (hold && (bus_if.bus_addr !== p_addr || bus_if.bus_dout !== p_dout ||
                         bus_if.bus_we !== p_we || bus_if.bus_ws !== p_ws)) unstable++;
            if (cen && bus_if.bus_ack) begin
               if (n_acc < 4) begin
                  acc_addr[n_acc] = bus_if.bus_addr; acc_dout[n_acc] = bus_if.bus_dout;
                  acc_we[n_acc] = bus_if.bus_we;     acc_ws[n_acc] = bus_if.bus_ws;
               end
               n_acc++; hold = 0; cnt = 0;
            end else begin
               hold = 1; p_addr = bus_if.bus_addr; p_dout = bus_if.bus_dout;
               p_we = bus_if.bus_we; p_ws = bus_if.bus_ws;
               if (cen) cnt++;
            end
         end else hold = 0;
         if ((xsp_we || iff_we || pc_we) && !cen) bad_strobe++;
         if (xsp_we) begin
            if (strobe_sig == 0) xsp_nx_first = xsp_nx;
            xsp_nx_last = xsp_nx; strobe_sig = strobe_sig * 4 + 1;
            upd_x = 1; upd_v = xsp_nx;
         end
         if (iff_we) begin iff_val = iff_nx; strobe_sig = strobe_sig * 4 + 2; end
         if (pc_we) begin pc_val = pc_nx; strobe_sig = strobe_sig * 4 + 3; done = 1; end
         if (mid_change && bus_if.bus_req && bus_if.bus_ws) begin
            int_vec = 6'd9; imask = 3'd7;
         end
         @(posedge clk); #1;
         if (upd_x) xsp = upd_v;
         insn_end = 1'b0;
      end
      int_lvl = 3'd0; bus_if.bus_ack = 1'b0; cen = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; cen = 1'b1; insn_end = 1'b0; int_lvl = 3'd0; int_vec = 6'd0;
      imask = 3'd0; xsp = '0; pc = '0; sr = '0;
      bus_if.bus_ack = 1'b0; bus_if.bus_din = '0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (all_out !== '0) $display("FAIL reset_outputs: got %h want 0", all_out);
      else n_pass++;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b0 || bus_if.bus_req !== 1'b0)
         $display("FAIL reset_release_idle: busy=%b req=%b want 0 0", busy, bus_if.bus_req);
      else n_pass++;
   endtask

   task automatic test_basic_entry;
      pc = 24'h001234; sr = 16'h8842; xsp = 32'h100; imask = 3'd3;
      int_lvl = 3'd4; int_vec = 6'd5; insn_end = 1'b1;
      run_seq(0, 0, 0, 32'h00ABCDEF);
      n_checks++;
      if (!done) $display("FAIL basic_timeout: pc_we seen=%b want 1", done); else n_pass++;
      n_checks++;
      if (ack_cnt != 1 || ackvec_val !== 6'd5)
         $display("FAIL basic_ack: count=%0d vec=%0d want 1 5", ack_cnt, ackvec_val);
      else n_pass++;
      n_checks++;
      if (n_acc != 3) $display("FAIL basic_acc_count: got %0d want 3", n_acc); else n_pass++;
      n_checks++;
      if (acc_addr[0] !== 24'h0000FC || acc_dout[0] !== 32'h00001234 || acc_we[0] !== 1 || acc_ws[0] !== 0)
         $display("FAIL basic_push_pc: addr=%h dout=%h we=%b ws=%b want 0000fc 00001234 1 0",
                  acc_addr[0], acc_dout[0], acc_we[0], acc_ws[0]);
      else n_pass++;
      n_checks++;
      if (acc_addr[1] !== 24'h0000FA || acc_dout[1] !== 32'h00008842 || acc_we[1] !== 1 || acc_ws[1] !== 1)
         $display("FAIL basic_push_sr: addr=%h dout=%h we=%b ws=%b want 0000fa 00008842 1 1",
                  acc_addr[1], acc_dout[1], acc_we[1], acc_ws[1]);
      else n_pass++;
      n_checks++;
      if (acc_addr[2] !== 24'hFFFF14 || acc_we[2] !== 0 || acc_ws[2] !== 0)
         $display("FAIL basic_rd_vec: addr=%h we=%b ws=%b want ffff14 0 0", acc_addr[2], acc_we[2], acc_ws[2]);
      else n_pass++;
      n_checks++;
      if (iff_val !== 3'd5 || pc_val !== 24'hABCDEF)
         $display("FAIL basic_iff_pc: iff=%0d pc=%h want 5 abcdef", iff_val, pc_val);
      else n_pass++;
      n_checks++;
      if (xsp !== 32'h000000FA || busy_cyc != 5)
         $display("FAIL basic_xsp_busy: xsp=%h busy_cycles=%0d want 000000fa 5", xsp, busy_cyc);
      else n_pass++;
      n_checks++;
      // xsp, xsp, iff, pc in that order
      if (strobe_sig != 91) $display("FAIL basic_strobe_order: got %0d want 91", strobe_sig);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || bus_if.bus_req !== 1'b0)
         $display("FAIL basic_return_idle: busy=%b req=%b want 0 0", busy, bus_if.bus_req);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_masking;
      int bad;
      bad = 0;
      imask = 3'd5; int_lvl = 3'd4; int_vec = 6'd2; insn_end = 1'b1; xsp = 32'h100;
      repeat (4) begin
         @(negedge clk);
         if (int_ack !== 1'b0 || busy !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      n_checks++;
      if (bad != 0) $display("FAIL mask_blocks: accepted cycles=%0d want 0", bad); else n_pass++;
      imask = 3'd7; int_lvl = 3'd7; int_vec = 6'd1;
      run_seq(0, 0, 0, 32'h00001000);
      n_checks++;
      if (!done || ack_cnt != 1 || iff_val !== 3'd7)
         $display("FAIL mask_lvl7: done=%b acks=%0d iff=%0d want 1 1 7", done, ack_cnt, iff_val);
      else n_pass++;
      n_checks++;
      if (acc_addr[2] !== 24'hFFFF04 || pc_val !== 24'h001000)
         $display("FAIL mask_lvl7_vec: addr=%h pc=%h want ffff04 001000", acc_addr[2], pc_val);
      else n_pass++;
   endtask

   task automatic test_wait_states;
      pc = 24'h001234; sr = 16'h8842; xsp = 32'h100; imask = 3'd3;
      int_lvl = 3'd4; int_vec = 6'd5; insn_end = 1'b1;
      run_seq(3, 0, 0, 32'h00ABCDEF);
      n_checks++;
      if (!done || busy_cyc != 14)
         $display("FAIL wait_latency: done=%b busy_cycles=%0d want 1 14", done, busy_cyc);
      else n_pass++;
      n_checks++;
      if (unstable != 0) $display("FAIL wait_stable: changes=%0d want 0", unstable); else n_pass++;
      n_checks++;
      if (n_acc != 3 || acc_addr[1] !== 24'h0000FA || acc_dout[0] !== 32'h00001234 || pc_val !== 24'hABCDEF)
         $display("FAIL wait_data: n=%0d addr1=%h dout0=%h pc=%h want 3 0000fa 00001234 abcdef",
                  n_acc, acc_addr[1], acc_dout[0], pc_val);
      else n_pass++;
   endtask

   task automatic test_mid_change;
      pc = 24'h001234; sr = 16'h8842; xsp = 32'h100; imask = 3'd3;
      int_lvl = 3'd4; int_vec = 6'd5; insn_end = 1'b1;
      run_seq(0, 0, 1, 32'h00ABCDEF);
      n_checks++;
      if (!done || acc_addr[2] !== 24'hFFFF14 || iff_val !== 3'd5)
         $display("FAIL mid_change: done=%b addr=%h iff=%0d want 1 ffff14 5", done, acc_addr[2], iff_val);
      else n_pass++;
      imask = 3'd3; int_vec = 6'd5;
   endtask

   task automatic test_wrap_and_cen;
      int sig_ref;
      pc = 24'h000400; sr = 16'h0001; xsp = 32'h2; imask = 3'd0;
      int_lvl = 3'd2; int_vec = 6'd3; insn_end = 1'b1;
      run_seq(0, 0, 0, 32'h00000500);
      sig_ref = strobe_sig;
      n_checks++;
      if (acc_addr[0] !== 24'hFFFFFE || xsp_nx_first !== 32'hFFFFFFFE || acc_addr[1] !== 24'hFFFFFC)
         $display("FAIL wrap_addr: a0=%h nx0=%h a1=%h want fffffe fffffffe fffffc",
                  acc_addr[0], xsp_nx_first, acc_addr[1]);
      else n_pass++;
      n_checks++;
      if (xsp_nx_last !== 32'hFFFFFFFC) $display("FAIL wrap_xsp: got %h want fffffffc", xsp_nx_last);
      else n_pass++;
      xsp = 32'h2; int_lvl = 3'd2; int_vec = 6'd3; insn_end = 1'b1;
      run_seq(0, 1, 0, 32'h00000500);
      // cen alternates 1/0 starting high: accept, then each of four states takes two cycles
      n_checks++;
      if (!done || busy_cyc != 9)
         $display("FAIL cen_latency: done=%b busy_cycles=%0d want 1 9", done, busy_cyc);
      else n_pass++;
      n_checks++;
      if (strobe_sig != sig_ref || strobe_sig != 91 || bad_strobe != 0)
         $display("FAIL cen_strobes: sig=%0d ref=%0d gated=%0d want 91 91 0", strobe_sig, sig_ref, bad_strobe);
      else n_pass++;
      n_checks++;
      if (xsp !== 32'hFFFFFFFC || pc_val !== 24'h000500 || iff_val !== 3'd3)
         $display("FAIL cen_values: xsp=%h pc=%h iff=%0d want fffffffc 000500 3", xsp, pc_val, iff_val);
      else n_pass++;
   endtask

   task automatic test_reset_abort;
      int bad;
      bad = 0;
      pc = 24'h001234; sr = 16'h8842; xsp = 32'h100; imask = 3'd3;
      int_lvl = 3'd4; int_vec = 6'd5; insn_end = 1'b1; bus_if.bus_ack = 1'b1;
      bus_if.bus_din = 32'h00ABCDEF;
      @(negedge clk);
      n_checks++;
      if (int_ack !== 1'b1) $display("FAIL abort_accept: int_ack=%b want 1", int_ack); else n_pass++;
      @(posedge clk); #1;
      insn_end = 1'b0; int_lvl = 3'd0;
      repeat (2) @(posedge clk);
      #1 bus_if.bus_ack = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (bus_if.bus_req !== 1'b1 || bus_if.bus_we !== 1'b0 || bus_if.bus_addr !== 24'hFFFF14)
         $display("FAIL abort_in_rd_vec: req=%b we=%b addr=%h want 1 0 ffff14",
                  bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (all_out !== '0) $display("FAIL abort_async_zero: got %h want 0", all_out); else n_pass++;
      bus_if.bus_ack = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (pc_we !== 1'b0 || busy !== 1'b0 || bus_if.bus_req !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) $display("FAIL abort_no_strobe: active cycles=%0d want 0", bad); else n_pass++;
      rst_n = 1'b1; bus_if.bus_ack = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || bus_if.bus_req !== 1'b0 || pc_we !== 1'b0)
         $display("FAIL abort_release_idle: busy=%b req=%b pc_we=%b want 0 0 0",
                  busy, bus_if.bus_req, pc_we);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic_entry();
      test_masking();
      test_wait_states();
      test_mid_change();
      test_wrap_and_cen();
      test_reset_abort();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
